// File: rtl/multiplicador4_sec_pkg.sv
// Shared constants and state encoding for the sequential 4x4 shift-and-add multiplier.
package multiplicador4_sec_pkg;

   localparam int ANCHO = 4;
   localparam int CNT_W = 2;

   typedef enum logic [1:0] {
      EST_IDLE = 2'd0,
      EST_CALC = 2'd1,
      EST_DONE = 2'd2
   } estado_t;

endpackage

// File: rtl/multiplicador4_sec_sumador4.sv
// 4-bit ripple-carry adder built from a chain of one-bit full-adder cells.
module multiplicador4_sec_sumador4
   import multiplicador4_sec_pkg::*;
(
   input  logic [ANCHO-1:0] a_i,
   input  logic [ANCHO-1:0] b_i,
   input  logic             c_i,
   output logic [ANCHO-1:0] s_o,
   output logic             c_o
);

   logic [ANCHO:0] carry;

   assign carry[0] = c_i;

   for (genvar i = 0; i < ANCHO; i++) begin : g_sumbit
      assign s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign c_o = carry[ANCHO];

endmodule

// File: rtl/multiplicador4_sec.sv
// Sequential 4x4 unsigned multiplier: one shared 4-bit adder, four shift-and-add
// iterations, start/done handshake and a registered 8-bit product.
module multiplicador4_sec
   import multiplicador4_sec_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [ANCHO-1:0]     A_i,
   input  logic [ANCHO-1:0]     B_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*ANCHO-1:0]   P_o
);

   estado_t                state_q, state_d;
   logic [ANCHO-1:0]       m_q, m_d;
   logic [ANCHO-1:0]       acc_q, acc_d;
   logic [ANCHO-1:0]       q_q, q_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2*ANCHO-1:0]     p_q, p_d;
   logic                   done_q, done_d;

   logic [ANCHO-1:0]       sum_b;
   logic [ANCHO-1:0]       sum_s;
   logic                   sum_c;

   assign sum_b = q_q[0] ? m_q : '0;

   multiplicador4_sec_sumador4 u_sumador4 (
      .a_i (acc_q),
      .b_i (sum_b),
      .c_i (1'b0),
      .s_o (sum_s),
      .c_o (sum_c)
   );

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      done_d  = 1'b0;
      case (state_q)
         EST_IDLE: begin
            if (start_i) begin
               m_d     = A_i;
               q_d     = B_i;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = EST_CALC;
            end
         end
         EST_CALC: begin
            // {carry,sum,Q} >> 1: the adder carry lands in ACC[3], so no separate carry flop survives
            {acc_d, q_d} = {sum_c, sum_s, q_q[ANCHO-1:1]};
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ANCHO - 1)) begin
               state_d = EST_DONE;
            end
         end
         EST_DONE: begin
            done_d  = 1'b1;
            p_d     = {acc_q, q_q};
            state_d = EST_IDLE;
         end
         default: begin
            state_d = EST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EST_IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q == EST_CALC) || (state_q == EST_DONE);
   assign done_o = done_q;
   assign P_o    = p_q;

endmodule
